// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-addressed memory port between the instruction-fetch unit (IF)
// and the load/store unit (D). At most one request is granted per cycle; the
// winner is driven combinationally onto the memory port, and the memory's
// combinational read data is captured so that the winner sees a registered
// response exactly one cycle after its grant.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on contention (winner is the
//                               requester that did not win last time)
//                  undefined -> fixed priority, data always wins contention
//
// Parameters:
//   AW  address width of both requesters and the memory port
//   DW  data width of the data requester and the memory port (>= 32)
//
// Ports:
//   clk, rst_i             clock, synchronous active-high reset
//   if_req_i/if_addr_i     fetch request and byte address
//   if_flush_i             drop the fetch response presented this cycle
//   if_gnt_o               fetch accepted this cycle
//   if_rvalid_o/if_rdata_o fetch response (32-bit instruction word)
//   d_req_i/d_we_i/d_be_i  data request, store flag, store byte enables
//   d_addr_i/d_wdata_i     data byte address, store data
//   d_gnt_o                data request accepted this cycle
//   d_rvalid_o/d_rdata_o   load data or store acknowledge (data 0)
//   mem_req_o ... mem_wdata_o  memory access of the current winner
//   mem_rdata_i            combinational read data for mem_addr_o
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rst_i,

    // Instruction-fetch requester
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    input  logic            if_flush_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,

    // Load/store requester
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [DW/8-1:0] d_be_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [DW-1:0]   d_rdata_o,

    // Memory port
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i
);

    // Owner encoding shared by the response register and last_gnt.
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic          r_last_gnt;   // winner of the most recent grant
    logic          r_rsp_valid;  // a response is due this cycle
    logic          r_rsp_owner;  // who the pending response belongs to
    logic          r_rsp_store;  // pending D response is a store ack
    logic [DW-1:0] r_rsp_data;   // memory data captured in the grant cycle

    // ------------------------------------------------------------------------
    // Combinational grant
    // ------------------------------------------------------------------------
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_any_gnt;

    // NOTE: every signal assigned in an always_comb gets a default on entry,
    // so no path through the block leaves it unassigned and no latch appears.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        // Grants are held off for the whole time reset is asserted.
        if (!rst_i) begin
            if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
                // Contention: the requester that did not win last time goes.
                if (r_last_gnt == OWNER_D) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_d_gnt  = 1'b1;
                end
`else
                // Contention: data always wins. r_last_gnt is still tracked.
                w_d_gnt = 1'b1;
`endif
            end else begin
                w_if_gnt = if_req_i;
                w_d_gnt  = d_req_i;
            end
        end
    end

    assign w_any_gnt = w_if_gnt | w_d_gnt;
    assign if_gnt_o  = w_if_gnt;
    assign d_gnt_o   = w_d_gnt;

    // ------------------------------------------------------------------------
    // Memory port mux: idle port is all zeros, fetch never writes.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req_o   = w_any_gnt;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_d_gnt) begin
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (w_if_gnt) begin
            mem_addr_o  = if_addr_i;
        end
    end

    // ------------------------------------------------------------------------
    // Response register and last-grant tracking
    // ------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the values from before this edge regardless of the
    // order of statements or of other always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            // NOTE: the captured data is cleared too, not just the valid bit,
            // so the response register is fully defined after reset.
            r_last_gnt  <= OWNER_IF;
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= OWNER_IF;
            r_rsp_store <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_last_gnt  <= w_d_gnt ? OWNER_D : OWNER_IF;
                r_rsp_owner <= w_d_gnt ? OWNER_D : OWNER_IF;
                r_rsp_store <= w_d_gnt & d_we_i;
                // A store ack carries no data, so nothing is captured for it.
                r_rsp_data  <= (w_d_gnt && d_we_i) ? '0 : mem_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response outputs. Only rst_i and if_flush_i gate them combinationally;
    // the data itself always comes from r_rsp_data, never from mem_rdata_i.
    // Gating with rst_i drops a response that would otherwise appear while
    // reset is being asserted.
    // ------------------------------------------------------------------------
    logic w_if_rsp;
    logic w_d_rsp;

    assign w_if_rsp = r_rsp_valid && (r_rsp_owner == OWNER_IF) && !if_flush_i && !rst_i;
    assign w_d_rsp  = r_rsp_valid && (r_rsp_owner == OWNER_D) && !rst_i;

    assign if_rvalid_o = w_if_rsp;
    assign if_rdata_o  = w_if_rsp ? r_rsp_data[31:0] : 32'h0;
    assign d_rvalid_o  = w_d_rsp;
    assign d_rdata_o   = (w_d_rsp && !r_rsp_store) ? r_rsp_data : '0;

endmodule
